// File: rtl/regfile_param.sv
// Integer register file: two combinational read ports, one write port, x0 hard-wired to zero,
// optional write-to-read bypass, freeze mode, debug read port and a sequenced initialiser.
module regfile_param #(
  parameter int XLEN      = 32,
  parameter int NREG      = 32,
  parameter int BYPASS    = 1,
  parameter int INIT_MODE = 1,
  localparam int AW       = $clog2(NREG)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            we,
  input  logic [AW-1:0]   waddr,
  input  logic [XLEN-1:0] wdata,
  input  logic [AW-1:0]   raddr1,
  input  logic [AW-1:0]   raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            freeze,
  input  logic [AW-1:0]   dbg_addr,
  output logic [XLEN-1:0] dbg_data,
  input  logic            init_req,
  output logic            busy,
  output logic            wr_drop
);

  typedef enum logic {
    INIT,
    RUN
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   ptr_q, ptr_d;
  logic            wr_drop_d;
  logic            accept;
  logic [XLEN-1:0] init_val;
  logic [XLEN-1:0] rf [0:NREG-1];

  assign busy     = (state_q == INIT);
  assign accept   = (state_q == RUN) && we && !freeze && !init_req && (waddr != '0);
  assign init_val = (INIT_MODE != 0) ? XLEN'(ptr_q) : '0;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    wr_drop_d = we && (waddr != '0) && !accept;
    case (state_q)
      INIT: begin
        ptr_d = ptr_q + AW'(1);
        if (ptr_q == AW'(NREG - 1)) begin
          state_d = RUN;
          ptr_d   = '0;
        end
      end
      RUN: begin
        if (init_req) begin
          state_d = INIT;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = INIT;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= INIT;
      ptr_q   <= '0;
      wr_drop <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      wr_drop <= wr_drop_d;
    end
  end

  // Storage has no reset; the initialiser rewrites every entry after each reset or request.
  always_ff @(posedge clk) begin
    if (state_q == INIT) begin
      rf[ptr_q] <= init_val;
    end else if (accept) begin
      rf[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1   = '0;
    rdata2   = '0;
    dbg_data = '0;
    if (!busy) begin
      if (raddr1 != '0) begin
        rdata1 = (BYPASS != 0 && accept && waddr == raddr1) ? wdata : rf[raddr1];
      end
      if (raddr2 != '0) begin
        rdata2 = (BYPASS != 0 && accept && waddr == raddr2) ? wdata : rf[raddr2];
      end
      if (dbg_addr != '0) begin
        dbg_data = rf[dbg_addr];
      end
    end
  end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param: bypassing and non-bypassing instances share stimulus,
// expectations go through a scoreboard queue and are checked with immediate assertions.
module tb_regfile_param;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            we;
  logic [AW-1:0]   waddr;
  logic [XLEN-1:0] wdata;
  logic [AW-1:0]   raddr1;
  logic [AW-1:0]   raddr2;
  logic            freeze;
  logic [AW-1:0]   dbg_addr;
  logic            init_req;

  logic [XLEN-1:0] rd1_b, rd2_b, dbg_b, rd1_n, rd2_n, dbg_n;
  logic            busy_b, drop_b, busy_n, drop_n;

  always #5 clk = ~clk;

  regfile_param #(.XLEN(XLEN), .NREG(NREG), .BYPASS(1), .INIT_MODE(1)) u_byp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_b), .rdata2(rd2_b),
    .freeze(freeze), .dbg_addr(dbg_addr), .dbg_data(dbg_b),
    .init_req(init_req), .busy(busy_b), .wr_drop(drop_b)
  );

  regfile_param #(.XLEN(XLEN), .NREG(NREG), .BYPASS(0), .INIT_MODE(1)) u_nobyp (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata),
    .raddr1(raddr1), .raddr2(raddr2), .rdata1(rd1_n), .rdata2(rd2_n),
    .freeze(freeze), .dbg_addr(dbg_addr), .dbg_data(dbg_n),
    .init_req(init_req), .busy(busy_n), .wr_drop(drop_n)
  );

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic expect_v(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic observe(input logic [31:0] obs);
    exp_t e;
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL sb_empty observed=%h expected=<none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic busy_window(input int first);
    for (int i = first; i <= NREG; i++) begin
      expect_v($sformatf("busy_b_e%0d", i), (i < NREG) ? 32'd1 : 32'd0);
      expect_v($sformatf("busy_n_e%0d", i), (i < NREG) ? 32'd1 : 32'd0);
      tick();
      observe(32'(busy_b));
      observe(32'(busy_n));
    end
  endtask

  task automatic scan_all();
    for (int a = 0; a < NREG; a++) begin
      dbg_addr = AW'(a);
      raddr1   = AW'(a);
      expect_v($sformatf("dbg_b_%0d", a), 32'(a));
      expect_v($sformatf("dbg_n_%0d", a), 32'(a));
      expect_v($sformatf("rd1_n_%0d", a), 32'(a));
      #1;
      observe(dbg_b);
      observe(dbg_n);
      observe(rd1_n);
    end
  endtask

  initial begin
    int sel[4];
    sel = '{3, 4, 7, 9};

    rst = 1'b1; we = 1'b0; freeze = 1'b0; init_req = 1'b0;
    waddr = '0; wdata = '0; raddr1 = 5'd3; raddr2 = 5'd4; dbg_addr = 5'd3;

    expect_v("rst_busy_b", 32'd1);
    expect_v("rst_busy_n", 32'd1);
    expect_v("rst_drop_b", 32'd0);
    expect_v("rst_drop_n", 32'd0);
    expect_v("rst_rd1_b", 32'd0);
    expect_v("rst_rd2_n", 32'd0);
    expect_v("rst_dbg_b", 32'd0);
    #12;
    observe(32'(busy_b)); observe(32'(busy_n));
    observe(32'(drop_b)); observe(32'(drop_n));
    observe(rd1_b); observe(rd2_n); observe(dbg_b);

    rst = 1'b0;
    busy_window(1);
    scan_all();

    // write x5, same-cycle visibility depends on bypass
    tick();
    raddr1 = 5'd5; we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
    expect_v("byp_rd1_same", 32'hDEADBEEF);
    expect_v("nobyp_rd1_same", 32'd5);
    #1;
    observe(rd1_b); observe(rd1_n);
    expect_v("byp_rd1_after", 32'hDEADBEEF);
    expect_v("nobyp_rd1_after", 32'hDEADBEEF);
    expect_v("w5_drop_b", 32'd0);
    tick();
    we = 1'b0;
    #1;
    observe(rd1_b); observe(rd1_n); observe(32'(drop_b));

    // write to x0 is ignored and not a drop
    tick();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF; raddr1 = 5'd0;
    expect_v("x0_rd1_b_same", 32'd0);
    expect_v("x0_rd1_n_same", 32'd0);
    #1;
    observe(rd1_b); observe(rd1_n);
    expect_v("x0_drop_b", 32'd0);
    expect_v("x0_drop_n", 32'd0);
    expect_v("x0_rd1_b_after", 32'd0);
    tick();
    we = 1'b0;
    #1;
    observe(32'(drop_b)); observe(32'(drop_n)); observe(rd1_b);

    // frozen write dropped
    freeze = 1'b1; we = 1'b1; waddr = 5'd7; wdata = 32'h1234; raddr2 = 5'd7;
    expect_v("frz_rd2_b_same", 32'd7);
    expect_v("frz_rd2_n_same", 32'd7);
    #1;
    observe(rd2_b); observe(rd2_n);
    expect_v("frz_drop_b", 32'd1);
    expect_v("frz_drop_n", 32'd1);
    expect_v("frz_rd2_b", 32'd7);
    expect_v("frz_rd2_n", 32'd7);
    tick();
    we = 1'b0; freeze = 1'b0;
    #1;
    observe(32'(drop_b)); observe(32'(drop_n)); observe(rd2_b); observe(rd2_n);
    expect_v("drop_clear_b", 32'd0);
    expect_v("drop_clear_n", 32'd0);
    tick();
    observe(32'(drop_b)); observe(32'(drop_n));

    we = 1'b1; waddr = 5'd7; wdata = 32'h1234;
    expect_v("w7_rd2_b_same", 32'h1234);
    expect_v("w7_rd2_n_same", 32'd7);
    #1;
    observe(rd2_b); observe(rd2_n);
    expect_v("w7_rd2_b", 32'h1234);
    expect_v("w7_rd2_n", 32'h1234);
    expect_v("w7_drop_n", 32'd0);
    tick();
    we = 1'b0;
    #1;
    observe(rd2_b); observe(rd2_n); observe(32'(drop_n));

    // re-initialisation request
    we = 1'b1; waddr = 5'd3; wdata = 32'hAA;
    tick();
    we = 1'b0; dbg_addr = 5'd3;
    expect_v("x3_dbg_b", 32'hAA);
    expect_v("x3_dbg_n", 32'hAA);
    #1;
    observe(dbg_b); observe(dbg_n);

    init_req = 1'b1; we = 1'b1; waddr = 5'd9; wdata = 32'h55; raddr1 = 5'd9;
    expect_v("ireq_rd1_b", 32'd9);
    expect_v("ireq_rd1_n", 32'd9);
    #1;
    observe(rd1_b); observe(rd1_n);
    expect_v("ireq_drop_b", 32'd1);
    expect_v("ireq_drop_n", 32'd1);
    expect_v("ireq_busy_b", 32'd1);
    tick();
    init_req = 1'b0; waddr = 5'd4; wdata = 32'h77;
    #1;
    observe(32'(drop_b)); observe(32'(drop_n)); observe(32'(busy_b));
    expect_v("init_drop_b", 32'd1);
    expect_v("init_drop_n", 32'd1);
    expect_v("init_busy_n", 32'd1);
    expect_v("init_dbg_b", 32'd0);
    tick();
    we = 1'b0;
    observe(32'(drop_b)); observe(32'(drop_n)); observe(32'(busy_n)); observe(dbg_b);
    busy_window(2);
    foreach (sel[k]) begin
      dbg_addr = AW'(sel[k]);
      expect_v($sformatf("reinit_dbg_b_%0d", sel[k]), 32'(sel[k]));
      expect_v($sformatf("reinit_dbg_n_%0d", sel[k]), 32'(sel[k]));
      #1;
      observe(dbg_b); observe(dbg_n);
    end

    // reset in the middle of INIT
    tick();
    we = 1'b1; waddr = 5'd2; wdata = 32'hCAFE;
    tick();
    waddr = 5'd20; wdata = 32'hBEEF;
    tick();
    we = 1'b0; init_req = 1'b1;
    tick();
    init_req = 1'b0;
    repeat (9) tick();
    we = 1'b1; waddr = 5'd6;
    tick();
    we = 1'b0;
    expect_v("mid_drop_b", 32'd1);
    expect_v("mid_drop_n", 32'd1);
    observe(32'(drop_b)); observe(32'(drop_n));
    rst = 1'b1;
    expect_v("mid_rst_busy_b", 32'd1);
    expect_v("mid_rst_drop_b", 32'd0);
    expect_v("mid_rst_drop_n", 32'd0);
    expect_v("mid_rst_rd1_n", 32'd0);
    #2;
    observe(32'(busy_b)); observe(32'(drop_b)); observe(32'(drop_n)); observe(rd1_n);
    tick();
    rst = 1'b0;
    busy_window(1);
    scan_all();

    if (sb.size() != 0) begin
      n_tests++;
      n_fail++;
      $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/regfile_param.md
# regfile_param

Parametrised integer register file for the single-cycle RISC-V core: two combinational read ports, one synchronous write port, and a hard-wired zero register. It adds an optional write-to-read bypass, a freeze (debug) mode and a separate debug read port for the board display path. It also has a sequenced initialiser that loads every register over NREG cycles after reset or on request, instead of in one cycle. It sits between decode (addresses), writeback (write data) and the ALU operand muxes.

## Interface
- XLEN, 32, data width in bits (≥8)
- NREG, 32, register count; power of two, ≥4
- AW, $clog2(NREG), address width (derived, not overridden)
- BYPASS, 1, 1 = same-cycle write data forwarded to read ports; 0 = reads return stored value
- INIT_MODE, 1, 0 = initialise all registers to 0; 1 = register i initialised to value i (zero-extended to XLEN)

- clk  in  1  core clock, rising edge
- rst  in  1  asynchronous, active-high reset
- we  in  1  write request
- waddr  in  AW  write register number
- wdata  in  XLEN  write data
- raddr1, raddr2  in  AW  read register numbers
- rdata1, rdata2  out  XLEN  read data (combinational)
- freeze  in  1  debug hold: architectural writes blocked
- dbg_addr  in  AW  debug read register number
- dbg_data  out  XLEN  debug read data (combinational)
- init_req  in  1  request re-initialisation (sampled in RUN only)
- busy  out  1  initialiser active
- wr_drop  out  1  registered pulse: a write request was discarded

## Operation
- FSM states: INIT, RUN.
- rst (async) sets state=INIT, ptr=0, busy=1 and wr_drop=0. Array contents are not cleared by rst; the initialiser overwrites them.
- INIT, per clock: rf[ptr] <= pattern(ptr); ptr <= ptr+1.
  - After writing ptr==NREG-1: state <= RUN and ptr <= 0.
  - pattern(0) is always 0.
- RUN: init_req=1 at a rising edge sets state <= INIT and ptr <= 0. No write occurs at that edge. init_req is ignored in INIT.
- Accepted write: state==RUN && we && !freeze && !init_req && waddr!=0.
  - An accepted write stores rf[waddr] <= wdata at the rising edge.
- Dropped write: we=1 but not accepted because of INIT, freeze or init_req.
  - A dropped write sets wr_drop=1 for the following cycle.
  - A write to waddr==0 is silently ignored and is not a drop.
- Reads:
  - Address 0 returns 0.
  - While busy, rdata1, rdata2 and dbg_data return 0.
  - Otherwise a read returns rf[addr].
- Bypass (BYPASS=1): if an accepted write targets a nonzero raddrN in the same cycle, rdataN = wdata.
  - dbg_data never bypasses.
- freeze does not affect reads, the debug port or the initialiser.

## Timing
- Reset outputs: busy=1, wr_drop=0, rdata1=rdata2=dbg_data=0.
- Initialisation takes exactly NREG rising edges after rst deasserts or after the init_req edge.
  - busy falls after the NREG-th edge.
  - The first accepted write is possible at the next edge.
- Write-to-read latency:
  - BYPASS=1: zero cycles (same cycle, via bypass).
  - BYPASS=0: one cycle (visible after the edge).
- wr_drop is asserted exactly one cycle after the edge that dropped the write and is cleared otherwise.
- rst asserted mid-INIT restarts at ptr=0.
- rst asserted mid-write: that write is lost; INIT rewrites the whole array.
- Read and write to the same address with BYPASS=0: the read returns the old value until the edge.

## Test plan
- Reset with NREG=32, INIT_MODE=1:
  - Release rst, hold busy check → busy=1 for 32 edges, then 0.
  - Debug-scan all addresses → dbg_data=i, with reg 0 = 0.
- Write with we=1, waddr=5, wdata=0xDEADBEEF, raddr1=5:
  - BYPASS=1 → rdata1=0xDEADBEEF in the same cycle.
  - BYPASS=0 → rdata1=5 before the edge, 0xDEADBEEF after.
- Write to x0 with we=1, waddr=0, wdata=0xFFFFFFFF → raddr1=0 returns 0 and wr_drop stays 0.
- freeze=1, we=1, waddr=7, wdata=0x1234 → wr_drop=1 next cycle and rf[7] stays 7. With freeze=0, the same write gives rf[7]=0x1234.
- init_req=1 after writing 0xAA to x3:
  - busy=1 for 32 cycles.
  - A write during this window → wr_drop=1.
  - Afterwards dbg_data(3)=3.
- Assert rst at ptr=10 of INIT → ptr restarts, busy=1 for a further full 32 edges, and the final contents equal the INIT pattern.
